// File: rtl/act_link_master_if.sv
// Stream and Activation-config signals between an act_link_master and its
// neighbours. The shared tri-state act bus stays a plain inout on the module.
`ifndef DataWidth
`define DataWidth 16
`endif

interface act_link_master_if #(
  parameter int DATA_W = `DataWidth
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        cfg_sel_i;
  logic              cfg_oe1;
  logic              cfg_oe2;
  logic              busy;
  logic [15:0]       op_cnt;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, cfg_sel_i, cfg_oe1, cfg_oe2, busy, op_cnt
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, cfg_sel_i, cfg_oe1, cfg_oe2, busy, op_cnt
  );
endinterface

// File: rtl/act_link_master.sv
// Initiator for the Activation unit's tri-state port: queues operands, drives
// each onto act_bus, turns the bus around and captures the activated result.
`ifndef DataWidth
`define DataWidth 16
`endif

module act_link_master #(
  parameter int DATA_W = `DataWidth,
  parameter int DEPTH  = 4,
  parameter int PORT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  act_link_master_if.master   lnk,
  inout  wire  [DATA_W-1:0]   act_bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] PORT_SEL = (PORT == 2) ? 2'b11 : 2'b10;

  typedef enum logic [1:0] {IDLE, DRIVE, XFER} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] fifo_mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              fifo_empty, fifo_full;
  logic              push, pop, slot_free;
  logic [DATA_W-1:0] drv_data;
  logic              bus_drv;
  logic [1:0]        cfg_sel_q;
  logic              oe1_q, oe2_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [15:0]       op_cnt_q;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push       = lnk.in_valid && !fifo_full;
  assign slot_free  = !out_valid_q || lnk.out_ready;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && slot_free) begin
          state_d = DRIVE;
          pop     = 1'b1;
        end
      end
      DRIVE: state_d = XFER;
      XFER: begin
        // The result captured this cycle occupies the slot next cycle, so
        // chaining straight into DRIVE needs a consumer that is accepting now.
        if (!fifo_empty && lnk.out_ready) begin
          state_d = DRIVE;
          pop     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; cfg and bus enable are decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cfg_sel_q <= 2'b00;
      oe1_q     <= 1'b0;
      oe2_q     <= 1'b0;
      bus_drv   <= 1'b0;
      op_cnt_q  <= 16'd0;
    end else begin
      state_q   <= state_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cfg_sel_q <= (state_d == DRIVE) ? PORT_SEL : 2'b00;
      oe1_q     <= (state_d == XFER) && (PORT != 2);
      oe2_q     <= (state_d == XFER) && (PORT == 2);
      bus_drv   <= (state_d == DRIVE);
      if (state_q == XFER) op_cnt_q <= op_cnt_q + 16'd1;
    end
  end

  // Operand storage; contents are only meaningful behind the pointers
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= lnk.in_data;
    if (pop)  drv_data <= fifo_mem[rd_ptr[AW-1:0]];
  end

  // Result slot
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (state_q == XFER) begin
      out_valid_q <= 1'b1;
      out_data_q  <= act_bus;
    end else if (out_valid_q && lnk.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign act_bus       = bus_drv ? drv_data : {DATA_W{1'bz}};
  assign lnk.in_ready  = !fifo_full;
  assign lnk.out_valid = out_valid_q;
  assign lnk.out_data  = out_data_q;
  assign lnk.cfg_sel_i = cfg_sel_q;
  assign lnk.cfg_oe1   = oe1_q;
  assign lnk.cfg_oe2   = oe2_q;
  assign lnk.busy      = (state_q != IDLE) || !fifo_empty;
  assign lnk.op_cnt    = op_cnt_q;

endmodule
